// File: rtl/rt_stage.sv
// Retire stage: retires the complete in-order prefix of the ROB head, emits registered
// AMT/freelist packets and sequences a drain-then-rollback on a retired mispredict.
module rt_stage #(
    parameter int C_RT_NUM       = 2,
    parameter int C_ARCH_REG_IDX = 5,
    parameter int C_TAG_IDX      = 6,
    parameter int C_PC_W         = 32,
    parameter int C_CNT_W        = 32
) (
    input  logic                                    clk_i,
    input  logic                                    rst_i,
    // per entry, MSB..LSB: {valid, complete, rd, tag, tag_old, br_mispredict, br_target}
    input  logic [C_RT_NUM-1:0][2+C_ARCH_REG_IDX+2*C_TAG_IDX+1+C_PC_W-1:0] rob_rt_i,
    output logic [$clog2(C_RT_NUM+1)-1:0]           rt_rob_o,
    // per channel, MSB..LSB: {rd, tag, wr_en}
    output logic [C_RT_NUM-1:0][C_ARCH_REG_IDX+C_TAG_IDX:0] dp_amt_o,
    // per channel, MSB..LSB: {tag_old, valid}
    output logic [C_RT_NUM-1:0][C_TAG_IDX:0]        rt_fl_o,
    output logic                                    rollback_o,
    output logic [C_PC_W-1:0]                       br_target_o,
    output logic [C_CNT_W-1:0]                      retired_cnt_o
);

    localparam int ENT_W  = 2 + C_ARCH_REG_IDX + 2*C_TAG_IDX + 1 + C_PC_W;
    localparam int RT_W   = $clog2(C_RT_NUM+1);
    localparam int MP_LSB = C_PC_W;
    localparam int TO_LSB = C_PC_W + 1;
    localparam int TG_LSB = C_PC_W + 1 + C_TAG_IDX;
    localparam int RD_LSB = C_PC_W + 1 + 2*C_TAG_IDX;

    typedef enum logic [1:0] {NORMAL, DRAIN, ROLLBACK} state_t;

    state_t state_reg, state_next;
    logic   rollback_reg, rollback_next;
    logic [C_PC_W-1:0]  br_target_reg, br_target_next;
    logic [C_CNT_W-1:0] retired_cnt_reg;

    logic [C_RT_NUM-1:0] ent_valid, ent_complete, ent_mp, retire;
    logic [C_RT_NUM-1:0][C_ARCH_REG_IDX-1:0] ent_rd;
    logic [C_RT_NUM-1:0][C_TAG_IDX-1:0]      ent_tag, ent_tag_old;
    logic [C_RT_NUM-1:0][C_PC_W-1:0]         ent_target;
    logic [C_RT_NUM-1:0][C_ARCH_REG_IDX+C_TAG_IDX:0] dp_amt_reg;
    logic [C_RT_NUM-1:0][C_TAG_IDX:0]        rt_fl_reg;
    logic [RT_W-1:0] rt_cnt;
    logic            run;
    logic            mp_hit;

    // Retirement is suppressed outside NORMAL and while reset is held.
    assign run = (state_reg == NORMAL) && rst_i;

    generate
        for (genvar gi = 0; gi < C_RT_NUM; gi++) begin : g_ch
            assign ent_valid[gi]    = rob_rt_i[gi][ENT_W-1];
            assign ent_complete[gi] = rob_rt_i[gi][ENT_W-2];
            assign ent_rd[gi]       = rob_rt_i[gi][RD_LSB +: C_ARCH_REG_IDX];
            assign ent_tag[gi]      = rob_rt_i[gi][TG_LSB +: C_TAG_IDX];
            assign ent_tag_old[gi]  = rob_rt_i[gi][TO_LSB +: C_TAG_IDX];
            assign ent_mp[gi]       = rob_rt_i[gi][MP_LSB];
            assign ent_target[gi]   = rob_rt_i[gi][C_PC_W-1:0];

            // A mispredicted older channel retires itself but blocks everything younger.
            if (gi == 0) begin : g_head
                assign retire[gi] = run && ent_valid[gi] && ent_complete[gi];
            end else begin : g_tail
                assign retire[gi] = retire[gi-1] && !ent_mp[gi-1]
                                    && ent_valid[gi] && ent_complete[gi];
            end

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    dp_amt_reg[gi] <= '0;
                    rt_fl_reg[gi]  <= '0;
                end else begin
                    dp_amt_reg[gi] <= {ent_rd[gi], ent_tag[gi],
                                       retire[gi] && (ent_rd[gi] != '0)};
                    rt_fl_reg[gi]  <= {ent_tag_old[gi],
                                       retire[gi] && (ent_rd[gi] != '0)};
                end
            end
        end
    endgenerate

    always_comb begin
        rt_cnt = '0;
        for (int i = 0; i < C_RT_NUM; i++) begin
            rt_cnt = rt_cnt + RT_W'(retire[i]);
        end
    end

    assign mp_hit = |(retire & ent_mp);

    always_comb begin
        state_next     = state_reg;
        rollback_next  = 1'b0;
        br_target_next = br_target_reg;
        for (int i = 0; i < C_RT_NUM; i++) begin
            if (retire[i] && ent_mp[i]) begin
                br_target_next = ent_target[i];
            end
        end
        case (state_reg)
            NORMAL:   if (mp_hit) state_next = DRAIN;
            DRAIN: begin
                state_next    = ROLLBACK;
                rollback_next = 1'b1;
            end
            ROLLBACK: state_next = NORMAL;
            default:  state_next = NORMAL;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_reg       <= NORMAL;
            rollback_reg    <= 1'b0;
            br_target_reg   <= '0;
            retired_cnt_reg <= '0;
        end else begin
            state_reg       <= state_next;
            rollback_reg    <= rollback_next;
            br_target_reg   <= br_target_next;
            retired_cnt_reg <= retired_cnt_reg + C_CNT_W'(rt_cnt);
        end
    end

    assign rt_rob_o      = rt_cnt;
    assign dp_amt_o      = dp_amt_reg;
    assign rt_fl_o       = rt_fl_reg;
    assign rollback_o    = rollback_reg;
    assign br_target_o   = br_target_reg;
    assign retired_cnt_o = retired_cnt_reg;

endmodule

// File: tb/tb_rt_stage.sv
// Bench for rt_stage: directed table, mispredict/reset sequences and random traffic
// checked against a prefix/stall-counter reference model.
module tb_rt_stage;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic [1:0][51:0]  rob_rt_i;
    logic [1:0]        rt_rob_o;
    logic [1:0][11:0]  dp_amt_o;
    logic [1:0][6:0]   rt_fl_o;
    logic              rollback_o;
    logic [31:0]       br_target_o;
    logic [31:0]       retired_cnt_o;

    rt_stage dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .rob_rt_i      (rob_rt_i),
        .rt_rob_o      (rt_rob_o),
        .dp_amt_o      (dp_amt_o),
        .rt_fl_o       (rt_fl_o),
        .rollback_o    (rollback_o),
        .br_target_o   (br_target_o),
        .retired_cnt_o (retired_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        v;
        logic        c;
        logic [4:0]  rd;
        logic [5:0]  tag;
        logic [5:0]  tag_old;
        logic        mp;
        logic [31:0] tgt;
    } ent_t;

    typedef struct {
        ent_t e0;
        ent_t e1;
        int   exp_n;
        logic exp_wr0;
        logic exp_wr1;
    } vec_t;

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_stall = 0;
    int unsigned m_cnt   = 0;
    logic [31:0] m_tgt   = 0;

    function automatic ent_t mk(logic v, logic c, int rd, int tag, int old, logic mp, logic [31:0] tgt);
        ent_t e;
        e.v = v; e.c = c; e.rd = 5'(rd); e.tag = 6'(tag); e.tag_old = 6'(old);
        e.mp = mp; e.tgt = tgt;
        return e;
    endfunction

    function automatic logic [51:0] pack(ent_t e);
        return {e.v, e.c, e.rd, e.tag, e.tag_old, e.mp, e.tgt};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Starts and ends just after a rising edge; covers one retire cycle.
    task automatic apply(input ent_t e0, input ent_t e1, output int seen_n);
        ent_t e[2];
        int   n;
        bit   mp_ret;
        bit   exp_rb;
        bit   exp_w;
        e[0] = e0; e[1] = e1;
        n = 0; mp_ret = 0;
        if (m_stall == 0) begin
            for (int i = 0; i < 2; i++) begin
                if (!(e[i].v && e[i].c)) break;
                n++;
                if (e[i].mp) begin
                    mp_ret = 1;
                    m_tgt  = e[i].tgt;
                    break;
                end
            end
        end
        exp_rb = (m_stall == 2);
        rob_rt_i = {pack(e1), pack(e0)};
        #2;
        seen_n = int'(rt_rob_o);
        chk("rt_rob", 32'(rt_rob_o), 32'(n));
        @(posedge clk_i); #1;
        m_cnt += n;
        chk("rollback", 32'(rollback_o), 32'(exp_rb));
        if (exp_rb) chk("br_target", br_target_o, m_tgt);
        chk("retired_cnt", retired_cnt_o, m_cnt);
        for (int i = 0; i < 2; i++) begin
            exp_w = (i < n) && (e[i].rd != 0);
            chk($sformatf("amt_wr%0d", i), 32'(dp_amt_o[i][0]), 32'(exp_w));
            chk($sformatf("fl_valid%0d", i), 32'(rt_fl_o[i][0]), 32'(exp_w));
            if (exp_w) begin
                chk($sformatf("amt_rd%0d", i), 32'(dp_amt_o[i][11:7]), 32'(e[i].rd));
                chk($sformatf("amt_tag%0d", i), 32'(dp_amt_o[i][6:1]), 32'(e[i].tag));
                chk($sformatf("fl_tag%0d", i), 32'(rt_fl_o[i][6:1]), 32'(e[i].tag_old));
            end
        end
        $display("txn t=%0t n=%0d rb=%0b cnt=%0d", $time, seen_n, rollback_o, retired_cnt_o);
        if (m_stall > 0) m_stall--;
        else if (mp_ret) m_stall = 2;
    endtask

    vec_t tbl[6];
    int   seen;
    ent_t a, b, ok0, ok1;

    initial begin
        tbl[0] = '{mk(1,1,3,40,3,0,0), mk(1,1,4,41,4,0,0), 2, 1'b1, 1'b1};
        tbl[1] = '{mk(1,0,3,40,3,0,0), mk(1,1,4,41,4,0,0), 0, 1'b0, 1'b0};
        tbl[2] = '{mk(1,1,0,12,0,0,0), mk(1,1,5,42,5,0,0), 2, 1'b0, 1'b1};
        tbl[3] = '{mk(1,1,7,50,9,0,0), mk(1,1,7,51,50,0,0), 2, 1'b1, 1'b1};
        tbl[4] = '{mk(1,1,8,20,8,0,0), mk(0,1,9,21,9,0,0), 1, 1'b1, 1'b0};
        tbl[5] = '{mk(0,1,8,20,8,0,0), mk(1,1,9,21,9,0,0), 0, 1'b0, 1'b0};
        ok0 = mk(1,1,10,30,10,0,0);
        ok1 = mk(1,1,11,31,11,0,0);

        // reset state with a retireable head present
        rob_rt_i = {pack(ok1), pack(ok0)};
        #12;
        chk("rst_rt_rob", 32'(rt_rob_o), 0);
        chk("rst_amt", 32'(dp_amt_o), 0);
        chk("rst_fl", 32'(rt_fl_o), 0);
        chk("rst_rollback", 32'(rollback_o), 0);
        chk("rst_br_target", br_target_o, 0);
        chk("rst_cnt", retired_cnt_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;

        // directed table
        for (int k = 0; k < 6; k++) begin
            apply(tbl[k].e0, tbl[k].e1, seen);
            chk($sformatf("tbl%0d_n", k), 32'(seen), 32'(tbl[k].exp_n));
            chk($sformatf("tbl%0d_wr0", k), 32'(dp_amt_o[0][0]), 32'(tbl[k].exp_wr0));
            chk($sformatf("tbl%0d_wr1", k), 32'(dp_amt_o[1][0]), 32'(tbl[k].exp_wr1));
        end

        // mispredict: drain, rollback, resume
        apply(mk(1,1,0,13,0,1,32'h1000), ok1, seen);
        chk("mp_n", 32'(seen), 1);
        apply(ok0, ok1, seen);
        chk("drain_n", 32'(seen), 0);
        chk("drain_rollback", 32'(rollback_o), 1);
        chk("drain_target", br_target_o, 32'h1000);
        apply(ok0, ok1, seen);
        chk("rollback_n", 32'(seen), 0);
        chk("post_rollback", 32'(rollback_o), 0);
        apply(ok0, ok1, seen);
        chk("resume_n", 32'(seen), 2);

        // reset during DRAIN
        apply(mk(1,1,6,14,6,1,32'h2000), ok1, seen);
        chk("mp2_n", 32'(seen), 1);
        rob_rt_i = {pack(ok1), pack(ok0)};
        rst_i = 1'b0;
        #1;
        chk("arst_rt_rob", 32'(rt_rob_o), 0);
        chk("arst_amt", 32'(dp_amt_o), 0);
        chk("arst_fl", 32'(rt_fl_o), 0);
        chk("arst_cnt", retired_cnt_o, 0);
        chk("arst_target", br_target_o, 0);
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        m_stall = 0; m_cnt = 0;
        apply(ok0, ok1, seen);
        chk("arst_resume_n", 32'(seen), 2);
        chk("arst_no_rollback", 32'(rollback_o), 0);

        // random traffic against the model
        for (int k = 0; k < 400; k++) begin
            a = mk($urandom_range(0,7) != 0, $urandom_range(0,3) != 0, $urandom_range(0,31),
                   $urandom_range(0,63), $urandom_range(0,63), $urandom_range(0,7) == 0, $urandom);
            b = mk($urandom_range(0,7) != 0, $urandom_range(0,3) != 0, $urandom_range(0,31),
                   $urandom_range(0,63), $urandom_range(0,63), $urandom_range(0,7) == 0, $urandom);
            apply(a, b, seen);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
